// File: rtl/ar_mem_seq.sv
// Two-beat sequencer moving 48-bit address-register values over a 24-bit data-memory port.
// Stalls the pipeline while busy and writes assembled load values back to the target AR.
module ar_mem_seq #(
  parameter int unsigned ADDR_W   = 48,
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned TGT_AR_W = 2
) (
  input  logic                iw_clk,
  input  logic                iw_rst,
  input  logic                iw_req_valid,
  input  logic                iw_req_we,
  input  logic [ADDR_W-1:0]   iw_req_addr,
  input  logic [ADDR_W-1:0]   iw_req_wdata,
  input  logic [TGT_AR_W-1:0] iw_req_tgt_ar,
  input  logic                iw_flush,
  output logic                ow_req_ready,
  output logic                ow_stall,
  output logic                ow_mem_valid,
  output logic                ow_mem_we,
  output logic [ADDR_W-1:0]   ow_mem_addr,
  output logic [DATA_W-1:0]   ow_mem_wdata,
  input  logic                iw_mem_ready,
  input  logic                iw_mem_rvalid,
  input  logic [DATA_W-1:0]   iw_mem_rdata,
  output logic                ow_ar_we,
  output logic [TGT_AR_W-1:0] ow_tgt_ar,
  output logic [ADDR_W-1:0]   ow_ar_result
);

  typedef enum logic [2:0] {
    StIdle,
    StLoIssue,
    StLoWait,
    StHiIssue,
    StHiWait,
    StWb
  } state_e;

  state_e                state_q, state_d;
  logic                  abort_q, abort_d;
  logic                  we_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [ADDR_W-1:0]     wdata_q;
  logic [TGT_AR_W-1:0]   tgt_q;
  logic [DATA_W-1:0]     lo_q;
  logic [ADDR_W-1:0]     result_q;

  logic accept;
  logic abort;
  logic beat_done;

  assign accept    = iw_req_valid && (state_q == StIdle) && !iw_flush;
  // A flush arriving this cycle counts the same as one already latched.
  assign abort     = abort_q || iw_flush;
  assign beat_done = ow_mem_valid && iw_mem_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept) state_d = StLoIssue;
      StLoIssue: begin
        if (beat_done)  state_d = we_q ? StHiIssue : StLoWait;
        else if (abort) state_d = StIdle;
      end
      StLoWait:  if (iw_mem_rvalid) state_d = abort ? StIdle : StHiIssue;
      StHiIssue: begin
        // A store's high beat always finishes so memory never holds a torn value.
        if (beat_done)           state_d = we_q ? StIdle : StHiWait;
        else if (abort && !we_q) state_d = StIdle;
      end
      StHiWait:  if (iw_mem_rvalid) state_d = abort ? StIdle : StWb;
      StWb:      state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    abort_d = abort_q || (iw_flush && (state_q != StIdle));
    if (state_d == StIdle) abort_d = 1'b0;
  end

  always_ff @(posedge iw_clk or negedge iw_rst) begin
    if (!iw_rst) begin
      state_q  <= StIdle;
      abort_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      tgt_q    <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
      if (accept) begin
        we_q    <= iw_req_we;
        addr_q  <= iw_req_addr;
        wdata_q <= iw_req_wdata;
        tgt_q   <= iw_req_tgt_ar;
      end
      if ((state_q == StLoWait) && iw_mem_rvalid) lo_q <= iw_mem_rdata;
      if ((state_q == StHiWait) && iw_mem_rvalid && !abort) begin
        result_q <= {iw_mem_rdata, lo_q};
      end
    end
  end

  assign ow_req_ready = (state_q == StIdle);
  assign ow_stall     = (state_q != StIdle);
  assign ow_mem_valid = (state_q == StLoIssue) || (state_q == StHiIssue);
  assign ow_mem_we    = ow_mem_valid && we_q;

  always_comb begin
    ow_mem_addr  = '0;
    ow_mem_wdata = '0;
    if (state_q == StLoIssue) begin
      ow_mem_addr  = addr_q;
      ow_mem_wdata = wdata_q[DATA_W-1:0];
    end else if (state_q == StHiIssue) begin
      ow_mem_addr  = addr_q + ADDR_W'(1);
      ow_mem_wdata = wdata_q[ADDR_W-1:DATA_W];
    end
  end

  assign ow_ar_we     = (state_q == StWb);
  assign ow_tgt_ar    = (state_q == StWb) ? tgt_q : '0;
  assign ow_ar_result = result_q;

endmodule

// File: tb/tb_ar_mem_seq.sv
// Self-checking bench for ar_mem_seq: a behavioural memory with configurable backpressure and
// read latency, plus a transaction-level model of expected beats, cycle counts and results.
module tb_ar_mem_seq;
  localparam int unsigned AW = 48;
  localparam int unsigned DW = 24;
  localparam int unsigned TW = 2;

  logic          iw_clk = 1'b0;
  logic          iw_rst;
  logic          iw_req_valid;
  logic          iw_req_we;
  logic [AW-1:0] iw_req_addr;
  logic [AW-1:0] iw_req_wdata;
  logic [TW-1:0] iw_req_tgt_ar;
  logic          iw_flush;
  logic          ow_req_ready;
  logic          ow_stall;
  logic          ow_mem_valid;
  logic          ow_mem_we;
  logic [AW-1:0] ow_mem_addr;
  logic [DW-1:0] ow_mem_wdata;
  logic          iw_mem_ready;
  logic          iw_mem_rvalid;
  logic [DW-1:0] iw_mem_rdata;
  logic          ow_ar_we;
  logic [TW-1:0] ow_tgt_ar;
  logic [AW-1:0] ow_ar_result;

  always #5 iw_clk = ~iw_clk;

  ar_mem_seq #(.ADDR_W(AW), .DATA_W(DW), .TGT_AR_W(TW)) dut (
    .iw_clk        (iw_clk),
    .iw_rst        (iw_rst),
    .iw_req_valid  (iw_req_valid),
    .iw_req_we     (iw_req_we),
    .iw_req_addr   (iw_req_addr),
    .iw_req_wdata  (iw_req_wdata),
    .iw_req_tgt_ar (iw_req_tgt_ar),
    .iw_flush      (iw_flush),
    .ow_req_ready  (ow_req_ready),
    .ow_stall      (ow_stall),
    .ow_mem_valid  (ow_mem_valid),
    .ow_mem_we     (ow_mem_we),
    .ow_mem_addr   (ow_mem_addr),
    .ow_mem_wdata  (ow_mem_wdata),
    .iw_mem_ready  (iw_mem_ready),
    .iw_mem_rvalid (iw_mem_rvalid),
    .iw_mem_rdata  (iw_mem_rdata),
    .ow_ar_we      (ow_ar_we),
    .ow_tgt_ar     (ow_tgt_ar),
    .ow_ar_result  (ow_ar_result)
  );

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } beat_t;

  beat_t         beats[$];
  logic [DW-1:0] mem     [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  int            cfg_stall  = 0;
  int            cfg_rdelay = 0;
  bit            spur       = 1'b0;
  int            errors     = 0;
  int            checks     = 0;

  function automatic logic [DW-1:0] fill(input logic [AW-1:0] a);
    return a[DW-1:0] ^ a[AW-1:DW] ^ 24'h5A3C96;
  endfunction

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : fill(a);
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : fill(a);
  endfunction

  // Memory: records handshaken beats, holds ready low cfg_stall cycles per beat, and
  // returns read data cfg_rdelay cycles after the minimum one-cycle latency.
  initial begin : responder
    bit            hs, hs_we, pend;
    logic [AW-1:0] hs_addr, pend_addr;
    logic [DW-1:0] hs_data;
    int            pend_cnt, wait_cnt;
    pend = 1'b0; pend_cnt = 0; wait_cnt = 0;
    iw_mem_ready = 1'b0; iw_mem_rvalid = 1'b0; iw_mem_rdata = '0;
    forever begin
      @(posedge iw_clk);
      hs      = iw_rst && ow_mem_valid && iw_mem_ready;
      hs_we   = ow_mem_we;
      hs_addr = ow_mem_addr;
      hs_data = ow_mem_wdata;
      @(negedge iw_clk);
      if (hs) begin
        beats.push_back('{hs_we, hs_addr, hs_data});
        wait_cnt = 0;
        if (hs_we) mem[hs_addr] = hs_data;
        else begin
          pend = 1'b1; pend_addr = hs_addr; pend_cnt = cfg_rdelay;
        end
      end
      iw_mem_rvalid = 1'b0;
      if (pend) begin
        if (pend_cnt == 0) begin
          iw_mem_rvalid = 1'b1;
          iw_mem_rdata  = mem_rd(pend_addr);
          pend          = 1'b0;
        end else pend_cnt--;
      end
      if (spur) begin
        iw_mem_rvalid = 1'b1;
        iw_mem_rdata  = DW'($urandom());
      end
      if (ow_mem_valid) begin
        if (wait_cnt < cfg_stall) begin
          iw_mem_ready = 1'b0; wait_cnt++;
        end else iw_mem_ready = 1'b1;
      end else begin
        iw_mem_ready = 1'b0; wait_cnt = 0;
      end
    end
  end

  task automatic step();
    @(negedge iw_clk);
    #1;
  endtask

  // Issues one request in the first idle cycle and follows it until the sequencer is idle.
  task automatic run_txn(input bit we, input logic [AW-1:0] addr, input logic [AW-1:0] wdata,
                         input logic [TW-1:0] tgt, input int stall, input int rdelay,
                         input int flush_cyc, output int cycles, output int arwe_cnt,
                         output int arwe_cyc, output logic [AW-1:0] res,
                         output logic [TW-1:0] res_tgt, output int bad);
    int k;
    cfg_stall = stall; cfg_rdelay = rdelay;
    k = 0;
    while (!ow_req_ready && k < 50) begin step(); k++; end
    beats.delete();
    arwe_cnt = 0; arwe_cyc = 0; res = '0; res_tgt = '0; bad = 0;
    iw_req_valid = 1'b1; iw_req_we = we; iw_req_addr = addr;
    iw_req_wdata = wdata; iw_req_tgt_ar = tgt;
    step();
    iw_req_valid = 1'b0;
    iw_req_wdata = {$urandom(), $urandom()};
    k = 1;
    while (!ow_req_ready && k <= 200) begin
      iw_flush = (k == flush_cyc);
      if (!ow_stall) bad++;
      if (ow_mem_valid) begin
        if (ow_mem_we !== we) bad++;
        if (beats.size() == 0) begin
          if (ow_mem_addr !== addr || (we && ow_mem_wdata !== wdata[DW-1:0])) bad++;
        end else if (ow_mem_addr !== addr + AW'(1) || (we && ow_mem_wdata !== wdata[AW-1:DW]))
          bad++;
      end
      if (ow_ar_we) begin
        arwe_cnt++; arwe_cyc = k; res = ow_ar_result; res_tgt = ow_tgt_ar;
      end
      step();
      k++;
    end
    iw_flush = 1'b0;
    cycles = k - 1;
    checks++;
    if (!ow_req_ready) begin
      errors++;
      $display("FAIL txn_timeout: ready=%0b after %0d cycles, required 1", ow_req_ready, cycles);
    end
  endtask

  task automatic test_reset();
    iw_rst = 1'b0;
    #1;
    checks++;
    if ({ow_stall, ow_mem_valid, ow_mem_we, ow_ar_we} !== 4'b0 || ow_mem_addr !== '0 ||
        ow_mem_wdata !== '0 || ow_tgt_ar !== '0 || ow_ar_result !== '0) begin
      errors++;
      $display("FAIL reset_outputs: stall=%0b valid=%0b we=%0b arwe=%0b addr=%0h res=%0h, required 0",
               ow_stall, ow_mem_valid, ow_mem_we, ow_ar_we, ow_mem_addr, ow_ar_result);
    end
    repeat (3) step();
    iw_rst = 1'b1;
    step();
    checks++;
    if (ow_req_ready !== 1'b1 || ow_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: ready=%0b stall=%0b, required 1/0", ow_req_ready, ow_stall);
    end
  endtask

  task automatic test_load_zero_wait();
    int cyc, n, wc, bad;
    logic [AW-1:0] res;
    logic [TW-1:0] t;
    mem[48'h10] = 24'h012345; ref_mem[48'h10] = 24'h012345;
    mem[48'h11] = 24'hABCDEF; ref_mem[48'h11] = 24'hABCDEF;
    run_txn(1'b0, 48'h10, '0, 2'd2, 0, 0, 0, cyc, n, wc, res, t, bad);
    checks++;
    if (cyc !== 5 || bad !== 0) begin
      errors++; $display("FAIL load_stall: cycles=%0d bad=%0d, required 5/0", cyc, bad);
    end
    checks++;
    if (n !== 1 || wc !== 5) begin
      errors++; $display("FAIL load_arwe: count=%0d cycle=%0d, required 1 at 5", n, wc);
    end
    checks++;
    if (res !== 48'hABCDEF_012345 || t !== 2'd2) begin
      errors++; $display("FAIL load_result: res=%0h tgt=%0d, required abcdef012345/2", res, t);
    end
    checks++;
    if (beats.size() != 2 || beats[0].addr !== 48'h10 || beats[1].addr !== 48'h11 ||
        beats[0].we || beats[1].we) begin
      errors++; $display("FAIL load_beats: n=%0d, required reads at 10 and 11", beats.size());
    end
  endtask

  task automatic test_store_backpressure();
    int cyc, n, wc, bad;
    logic [AW-1:0] res;
    logic [TW-1:0] t;
    run_txn(1'b1, 48'h20, 48'h111122_333344, 2'd1, 2, 0, 0, cyc, n, wc, res, t, bad);
    ref_mem[48'h20] = 24'h333344; ref_mem[48'h21] = 24'h111122;
    checks++;
    if (cyc !== 6 || n !== 0 || bad !== 0) begin
      errors++;
      $display("FAIL store_bp: cycles=%0d arwe=%0d bad=%0d, required 6/0/0", cyc, n, bad);
    end
    checks++;
    if (beats.size() != 2 || beats[0].data !== 24'h333344 || beats[0].addr !== 48'h20 ||
        beats[1].data !== 24'h111122 || beats[1].addr !== 48'h21 || !beats[0].we) begin
      errors++; $display("FAIL store_beats: n=%0d, required 333344@20 111122@21", beats.size());
    end
  endtask

  task automatic test_wrap();
    int cyc, n, wc, bad;
    logic [AW-1:0] res, a;
    logic [TW-1:0] t;
    a = '1;
    run_txn(1'b0, a, '0, 2'd3, 1, 1, 0, cyc, n, wc, res, t, bad);
    checks++;
    if (beats.size() != 2 || beats[1].addr !== '0 || beats[0].addr !== a) begin
      errors++; $display("FAIL wrap_addr: n=%0d, required high beat at 0", beats.size());
    end
    checks++;
    if (res !== {ref_rd('0), ref_rd(a)} || cyc !== 9 || n !== 1 || bad !== 0) begin
      errors++;
      $display("FAIL wrap_result: res=%0h cycles=%0d, required %0h/9", res, cyc,
               {ref_rd('0), ref_rd(a)});
    end
  endtask

  task automatic test_flush_load();
    int cyc, n, wc, bad;
    logic [AW-1:0] res;
    logic [TW-1:0] t;
    run_txn(1'b0, 48'h30, '0, 2'd1, 0, 3, 2, cyc, n, wc, res, t, bad);
    checks++;
    if (cyc !== 5 || n !== 0 || beats.size() != 1 || bad !== 0) begin
      errors++;
      $display("FAIL flush_load: cycles=%0d arwe=%0d beats=%0d, required 5/0/1", cyc, n,
               beats.size());
    end
  endtask

  task automatic test_flush_store();
    int cyc, n, wc, bad;
    logic [AW-1:0] res;
    logic [TW-1:0] t;
    run_txn(1'b1, 48'h40, 48'hAAAAAA_BBBBBB, 2'd0, 0, 0, 2, cyc, n, wc, res, t, bad);
    ref_mem[48'h40] = 24'hBBBBBB; ref_mem[48'h41] = 24'hAAAAAA;
    checks++;
    if (cyc !== 2 || beats.size() != 2 || beats[1].data !== 24'hAAAAAA || bad !== 0) begin
      errors++;
      $display("FAIL flush_store_hi: cycles=%0d beats=%0d, required 2/2", cyc, beats.size());
    end
    run_txn(1'b1, 48'h50, 48'hCCCCCC_DDDDDD, 2'd0, 1, 0, 3, cyc, n, wc, res, t, bad);
    ref_mem[48'h50] = 24'hDDDDDD; ref_mem[48'h51] = 24'hCCCCCC;
    checks++;
    if (cyc !== 4 || beats.size() != 2 || bad !== 0) begin
      errors++;
      $display("FAIL flush_store_hi_bp: cycles=%0d beats=%0d, required 4/2", cyc, beats.size());
    end
    run_txn(1'b1, 48'h60, 48'hEEEEEE_FFFFFF, 2'd0, 5, 0, 1, cyc, n, wc, res, t, bad);
    checks++;
    if (cyc !== 1 || beats.size() != 0 || ow_mem_valid !== 1'b0 || bad !== 0) begin
      errors++;
      $display("FAIL flush_store_lo: cycles=%0d beats=%0d valid=%0b, required 1/0/0", cyc,
               beats.size(), ow_mem_valid);
    end
  endtask

  task automatic test_flush_idle();
    iw_req_valid = 1'b1; iw_req_we = 1'b0; iw_req_addr = 48'h70; iw_flush = 1'b1;
    step();
    iw_req_valid = 1'b0; iw_flush = 1'b0;
    checks++;
    if (ow_req_ready !== 1'b1 || ow_stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: ready=%0b stall=%0b, required 1/0", ow_req_ready, ow_stall);
    end
  endtask

  task automatic test_spurious_rvalid();
    logic [AW-1:0] r;
    int bad;
    bad = 0;
    r = ow_ar_result;
    spur = 1'b1;
    step();
    spur = 1'b0;
    repeat (3) begin
      step();
      if (ow_ar_we || !ow_req_ready || ow_stall) bad++;
    end
    checks++;
    if (bad !== 0 || ow_ar_result !== r) begin
      errors++;
      $display("FAIL spurious_rvalid: bad=%0d res=%0h, required 0/%0h", bad, ow_ar_result, r);
    end
  endtask

  task automatic test_reset_rvalid();
    int bad;
    bad = 0;
    cfg_stall = 0; cfg_rdelay = 2;
    iw_req_valid = 1'b1; iw_req_we = 1'b0; iw_req_addr = 48'h200; iw_req_tgt_ar = 2'd1;
    step();
    iw_req_valid = 1'b0;
    repeat (5) step();
    checks++;
    if (ow_stall !== 1'b1 || ow_mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL hiwait_reach: stall=%0b valid=%0b, required 1/0", ow_stall, ow_mem_valid);
    end
    iw_rst = 1'b0;
    #1;
    checks++;
    if ({ow_stall, ow_mem_valid, ow_mem_we, ow_ar_we} !== 4'b0 || ow_mem_addr !== '0 ||
        ow_mem_wdata !== '0 || ow_tgt_ar !== '0 || ow_ar_result !== '0) begin
      errors++;
      $display("FAIL reset_midtxn: stall=%0b valid=%0b res=%0h, required all 0", ow_stall,
               ow_mem_valid, ow_ar_result);
    end
    step();
    iw_rst = 1'b1;
    repeat (5) begin
      step();
      if (ow_ar_we || !ow_req_ready || ow_ar_result !== '0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL reset_pending_rvalid: bad=%0d, required 0", bad);
    end
  endtask

  task automatic test_random();
    int cyc, n, wc, bad, s, d, exp_cyc;
    logic [AW-1:0] res, a, wd, exp_res;
    logic [TW-1:0] t, tg;
    bit we;
    logic [AW-1:0] pool[4];
    pool[0] = '1; pool[1] = '0; pool[2] = 48'h100; pool[3] = 48'h7FFF_FFFF_FFFF;
    for (int i = 0; i < 30; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? {$urandom(), $urandom()} : pool[$urandom_range(0, 3)];
      wd = {$urandom(), $urandom()};
      tg = TW'($urandom());
      s  = $urandom_range(0, 2);
      d  = $urandom_range(0, 2);
      exp_res = {ref_rd(a + AW'(1)), ref_rd(a)};
      exp_cyc = we ? 2 + 2 * s : 5 + 2 * s + 2 * d;
      run_txn(we, a, wd, tg, s, d, 0, cyc, n, wc, res, t, bad);
      if (we) begin
        ref_mem[a] = wd[DW-1:0]; ref_mem[a + AW'(1)] = wd[AW-1:DW];
      end
      checks++;
      if (cyc !== exp_cyc || bad !== 0) begin
        errors++;
        $display("FAIL rand_timing[%0d]: cycles=%0d bad=%0d, required %0d/0", i, cyc, bad,
                 exp_cyc);
      end
      checks++;
      if (beats.size() != 2 || beats[0].addr !== a || beats[1].addr !== a + AW'(1) ||
          beats[0].we != we || (we && {beats[1].data, beats[0].data} !== wd)) begin
        errors++; $display("FAIL rand_beats[%0d]: n=%0d addr=%0h", i, beats.size(), a);
      end
      checks++;
      if (we ? (n !== 0) : (n !== 1 || wc !== exp_cyc || res !== exp_res || t !== tg)) begin
        errors++;
        $display("FAIL rand_wb[%0d]: arwe=%0d res=%0h tgt=%0d, required %0h/%0d", i, n, res, t,
                 we ? '0 : exp_res, tg);
      end
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    iw_rst = 1'b0; iw_req_valid = 1'b0; iw_req_we = 1'b0; iw_req_addr = '0;
    iw_req_wdata = '0; iw_req_tgt_ar = '0; iw_flush = 1'b0;
    test_reset();
    test_load_zero_wait();
    test_store_backpressure();
    test_wrap();
    test_flush_load();
    test_flush_store();
    test_flush_idle();
    test_spurious_rvalid();
    test_reset_rvalid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ar_mem_seq.md
# ar_mem_seq

Multi-cycle sequencer that moves 48-bit address-register (AR) values over the 24-bit data-memory port. It sits between the EX stage and the MO stage. EX hands it an AR load or store with a computed address, such as the LDAso address or an AR store. It splits the access into a low-word beat and a high-word beat, stalls the pipeline while busy, and for loads writes the assembled 48-bit value back to the target AR.

## Interface
Parameters:
- ADDR_W, 48, AR and address width
- DATA_W, 24, memory data width; ADDR_W must equal 2*DATA_W
- TGT_AR_W, 2, target AR index width

Ports:
- iw_clk  in  1  clock; all state updates on its rising edge
- iw_rst  in  1  reset, asynchronous, active-low
- iw_req_valid  in  1  EX presents an AR memory request
- iw_req_we  in  1  1 = store AR to memory, 0 = load AR from memory
- iw_req_addr  in  ADDR_W  word address of the low half
- iw_req_wdata  in  ADDR_W  AR value to store
- iw_req_tgt_ar  in  TGT_AR_W  AR index to write on load
- iw_flush  in  1  pipeline flush
- ow_req_ready  out  1  sequencer idle and able to accept
- ow_stall  out  1  hold upstream pipeline stages
- ow_mem_valid  out  1  memory beat request
- ow_mem_we  out  1  beat is a write
- ow_mem_addr  out  ADDR_W  beat word address
- ow_mem_wdata  out  DATA_W  beat write data
- iw_mem_ready  in  1  memory accepts the beat this cycle
- iw_mem_rvalid  in  1  read data valid
- iw_mem_rdata  in  DATA_W  read data
- ow_ar_we  out  1  one-cycle AR write strobe
- ow_tgt_ar  out  TGT_AR_W  AR index for the write
- ow_ar_result  out  ADDR_W  assembled load value

## Operation
- **States:**
  - IDLE: accept a request.
  - LO_ISSUE: present the low beat.
  - LO_WAIT: load only; wait for low data.
  - HI_ISSUE: present the high beat.
  - HI_WAIT: load only; wait for high data.
  - WB: load only; write back to the AR.
- **Acceptance:**
  - A request is accepted when iw_req_valid, ow_req_ready and !iw_flush are all high.
  - On acceptance, addr, we, wdata and tgt_ar are captured.
  - Next state is LO_ISSUE.
- **Beat addressing and data:**
  - The low beat uses addr with wdata[DATA_W-1:0].
  - The high beat uses addr+1, taken modulo 2^ADDR_W, so all-ones wraps to 0; its data is wdata[ADDR_W-1:DATA_W].
- **Beat handshake:**
  - A beat completes on ow_mem_valid & iw_mem_ready.
  - Address, data and we stay stable while valid is high and ready is low.
- **Beat completion transitions:**
  - Store: LO_ISSUE→HI_ISSUE, then HI_ISSUE→IDLE.
  - Load: LO_ISSUE→LO_WAIT, then HI_ISSUE→HI_WAIT.
- **Read returns:**
  - LO_WAIT captures rdata into the low half on rvalid, then goes to HI_ISSUE.
  - HI_WAIT captures rdata into the high half on rvalid, then goes to WB.
  - rvalid in any other state is ignored.
  - At most one outstanding read.
- **WB:**
  - ow_ar_we=1 for exactly one cycle, with ow_tgt_ar = captured index and ow_ar_result = {hi,lo}.
  - Next state is IDLE.
  - ow_ar_result holds its value until the next WB.
- **Outputs:**
  - ow_req_ready = (state==IDLE).
  - ow_stall = (state!=IDLE).
- **Flush (sticky abort flag, cleared on return to IDLE):**
  - Load in LO_ISSUE or HI_ISSUE before acceptance: drop valid and go to IDLE next cycle.
  - Load in a *_WAIT state: stay until rvalid, then go to IDLE; no WB, no further beats.
  - Load in WB: the write still occurs.
  - Store in LO_ISSUE before acceptance: abort to IDLE.
  - Store in HI_ISSUE: the high beat completes normally, so no torn write.
  - Flush in IDLE blocks acceptance that cycle.
- **Reset:**
  - Asynchronous and immediate from any state.
  - State goes to IDLE and the abort flag clears.
  - All outputs are 0 except ow_req_ready=1 once reset is released.
  - A pending memory response after reset is ignored.

## Timing
- **Load, zero-wait memory** (ready=1, rvalid exactly 1 cycle after acceptance), counted from acceptance at cycle 0:
  - cycle 1: low beat accepted
  - cycle 2: low rvalid
  - cycle 3: high beat accepted
  - cycle 4: high rvalid
  - cycle 5: ow_ar_we
  - cycle 6: IDLE
  - Total 6 cycles; ow_stall high in cycles 1–5.
- **Store, zero-wait memory:**
  - cycle 1: low beat
  - cycle 2: high beat
  - cycle 3: IDLE
  - ow_stall high in cycles 1–2.
- Each cycle of iw_mem_ready=0 or of delayed rvalid adds one cycle to the affected state.
- Back-to-back requests: the next acceptance is possible in the first IDLE cycle.
- All outputs are registered or decoded from state only; there is no combinational path from iw_mem_* to ow_mem_*.

## Test plan
- **Load, zero-wait:** addr=0x000000_000010, tgt_ar=2, memory returns 0x012345 then 0xABCDEF → beats at 0x10 and 0x11; ow_ar_we at cycle 5 with ow_tgt_ar=2 and ow_ar_result=0xABCDEF_012345; ow_stall high in cycles 1–5.
- **Store with backpressure:** wdata=0x111122_333344, ready low for 2 cycles on each beat → write 0x333344 @A, then 0x111122 @A+1; data stable during the waits; IDLE at cycle 7; ow_ar_we never asserted.
- **Wrap:** load at addr=0xFFFFFF_FFFFFF → high beat address is 0x000000_000000.
- **Flush during load:** flush asserted in LO_WAIT, rvalid arrives 3 cycles later → no high beat and no ow_ar_we; IDLE in the cycle after rvalid.
- **Flush during store:** flush asserted in HI_ISSUE → high beat still issued and completed, then IDLE. Flush asserted in LO_ISSUE with ready=0 → ow_mem_valid drops and state goes to IDLE with no write.
- **Reset and spurious rvalid:** iw_rst=0 in HI_WAIT → all outputs 0 immediately; a following rvalid is ignored; after release ow_req_ready=1. A spurious rvalid in IDLE changes nothing.
